// File: rtl/afifo_wr_arbiter_pkg.sv
// Shared types and helpers for the async-FIFO write-side arbiter.
package afifo_arb_pkg;

  // Arbiter FSM: IDLE picks an owner, BURST streams that owner's packet.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of an index into n items; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/afifo_wr_arbiter_if.sv
// Requester bundle plus FIFO write port and arbiter status.
interface afifo_wr_arbiter_if #(
  parameter int nreq  = 4,
  parameter int dbits = 32
);
  logic [nreq-1:0]                          i_req_valid;
  logic [nreq*dbits-1:0]                    i_req_data;
  logic [nreq-1:0]                          i_req_last;
  logic [nreq-1:0]                          o_req_ready;
  logic                                     i_full;
  logic                                     o_wena;
  logic [dbits:0]                           o_wdata;
  logic [afifo_arb_pkg::idx_w(nreq)-1:0]    o_grant_id;
  logic                                     o_busy;
  logic                                     o_err;

  // Arbiter side.
  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_full,
    output o_req_ready, o_wena, o_wdata, o_grant_id, o_busy, o_err
  );

  // Requesters / FIFO / observer side.
  modport master (
    output i_req_valid, i_req_data, i_req_last, i_full,
    input  o_req_ready, o_wena, o_wdata, o_grant_id, o_busy, o_err
  );
endinterface

// File: rtl/afifo_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i.
module afifo_rr_pick
  import afifo_arb_pkg::*;
#(
  parameter int nreq = 4
) (
  input  logic [nreq-1:0]          req_i,
  input  logic [idx_w(nreq)-1:0]   ptr_i,
  output logic                     found_o,
  output logic [idx_w(nreq)-1:0]   idx_o
);
  localparam int IW = idx_w(nreq);

  int            j;
  logic [IW-1:0] j_idx;

  // Scan offsets from the far end back so the smallest offset wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    j_idx   = '0;
    for (int i = nreq - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= nreq) j = j - nreq;
      j_idx = IW'(j);
      if (req_i[j_idx]) begin
        found_o = 1'b1;
        idx_o   = j_idx;
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Packet-granular round-robin arbiter feeding the write side of an async FIFO.
module afifo_wr_arbiter
  import afifo_arb_pkg::*;
#(
  parameter int nreq       = 4,
  parameter int dbits      = 32,
  parameter int tmo_cycles = 16
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  afifo_wr_arbiter_if.slave  bus
);
  localparam int IW = idx_w(nreq);
  localparam int SW = $clog2(tmo_cycles + 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          err_q, err_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             own_valid;
  logic             own_last;
  logic [dbits-1:0] own_data;
  logic             beat;
  logic [IW-1:0]    next_ptr;
  logic [nreq-1:0]  ready_vec;

  afifo_rr_pick #(.nreq(nreq)) u_pick (
    .req_i   (bus.i_req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign own_valid = bus.i_req_valid[gid_q];
  assign own_last  = bus.i_req_last[gid_q];
  assign own_data  = bus.i_req_data[int'(gid_q)*dbits +: dbits];
  assign beat      = (state_q == BURST) && own_valid && !bus.i_full;
  // The requester after the owner gets first look at the next arbitration.
  assign next_ptr  = (gid_q == IW'(nreq - 1)) ? '0 : gid_q + 1'b1;

  // Next-state: arbitration in IDLE, beat / stall / timeout handling in BURST.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    stall_d  = stall_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gid_d   = pick_idx;
          stall_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          stall_d = '0;
          if (own_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!own_valid) begin
          // Owner went quiet: give up the FIFO once the budget is spent.
          if (stall_q == SW'(tmo_cycles - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
            err_d    = 1'b1;
            stall_d  = '0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
        // Valid but FIFO full: hold everything, the stall is not the owner's.
      end
      default: state_d = IDLE;
    endcase
  end

  // All FSM, pointer, counter and flag registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!i_nrst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      stall_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
    end
  end

  // One-hot ready at the owner's slot, mirroring the write enable.
  always_comb begin
    ready_vec        = '0;
    ready_vec[gid_q] = beat;
  end

  assign bus.o_req_ready = ready_vec;
  assign bus.o_wena      = beat;
  assign bus.o_wdata     = (state_q == BURST) ? {own_last, own_data} : '0;
  assign bus.o_grant_id  = gid_q;
  assign bus.o_busy      = (state_q == BURST);
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Scoreboard bench: directed scenarios plus randomized traffic vs a reference model.
module tb_afifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int DBITS = 32;
  localparam int TMO   = 16;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       valid = '0;
  logic [NREQ-1:0]       last  = '0;
  logic [NREQ*DBITS-1:0] data  = '0;
  logic                  full  = 1'b0;

  afifo_wr_arbiter_if #(.nreq(NREQ), .dbits(DBITS)) bus ();
  assign bus.i_req_valid = valid;
  assign bus.i_req_data  = data;
  assign bus.i_req_last  = last;
  assign bus.i_full      = full;

  afifo_wr_arbiter #(.nreq(NREQ), .dbits(DBITS), .tmo_cycles(TMO)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DBITS:0] wdata;
    int             gid;
  } wr_t;

  wr_t exp_q[$];
  int  gid_log[$];

  // Reference model: owner < 0 means nobody holds the FIFO.
  int              m_owner = -1;
  int              m_ptr   = 0;
  int              m_stall = 0;
  int              m_gid   = 0;
  bit              m_err   = 1'b0;
  int              m_acc   = -1;
  bit              exp_busy;
  bit              exp_err;
  int              exp_gid;
  logic [NREQ-1:0] exp_ready;

  // Model: predicts this cycle's outputs and applies the spec rules for the edge.
  initial begin : model
    int  k;
    bit  hit;
    forever begin
      @(negedge clk);
      #1;
      exp_busy  = (m_owner >= 0);
      exp_gid   = m_gid;
      exp_err   = m_err;
      exp_ready = '0;
      m_acc     = -1;
      if (!nrst) begin
        m_owner = -1; m_ptr = 0; m_stall = 0; m_gid = 0; m_err = 1'b0;
        exp_busy = 1'b0; exp_gid = 0; exp_err = 1'b0;
      end else if (m_owner < 0) begin
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          k = (m_ptr + i) % NREQ;
          if (!hit && valid[k]) begin
            hit = 1'b1; m_owner = k; m_gid = k; m_stall = 0;
          end
        end
      end else if (valid[m_owner] && !full) begin
        exp_ready[m_owner] = 1'b1;
        m_acc = m_owner;
        exp_q.push_back('{wdata: {last[m_owner], data[m_owner*DBITS +: DBITS]}, gid: m_owner});
        m_stall = 0;
        if (last[m_owner]) begin
          m_ptr = (m_owner + 1) % NREQ;
          m_owner = -1;
        end
      end else if (!valid[m_owner]) begin
        m_stall++;
        if (m_stall == TMO) begin
          m_err = 1'b1;
          m_ptr = (m_owner + 1) % NREQ;
          m_owner = -1;
          m_stall = 0;
        end
      end
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each write.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      #2;
      check("busy", bus.o_busy, exp_busy);
      check("grant_id", bus.o_grant_id, exp_gid);
      check("err", bus.o_err, exp_err);
      check("req_ready", bus.o_req_ready, exp_ready);
      if (bus.o_wena === 1'b1) begin
        gid_log.push_back(int'(bus.o_grant_id));
        if (exp_q.size() == 0) begin
          check("unexpected_write", bus.o_wena, 0);
        end else begin
          e = exp_q.pop_front();
          check("wdata", bus.o_wdata, e.wdata);
          check("write_gid", bus.o_grant_id, e.gid);
        end
      end
      if (exp_q.size() != 0) begin
        check("missing_write", bus.o_wena, 1);
        exp_q.delete();
      end
    end
  end

  task automatic check_zero(input string p);
    check({p, "_wena"}, bus.o_wena, 0);
    check({p, "_ready"}, bus.o_req_ready, 0);
    check({p, "_busy"}, bus.o_busy, 0);
    check({p, "_err"}, bus.o_err, 0);
    check({p, "_gid"}, bus.o_grant_id, 0);
    check({p, "_wdata"}, bus.o_wdata, 0);
  endtask

  // Expected grant order packed one nibble per write, first write in the top nibble.
  task automatic check_gids(input string name, input int n, input logic [31:0] exp);
    logic [31:0] e;
    check({name, "_count"}, gid_log.size(), n);
    for (int i = 0; i < n && i < gid_log.size(); i++) begin
      e = (exp >> (4 * (n - 1 - i))) & 32'hF;
      check({name, "_gid"}, gid_log[i], e);
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < NREQ; k++) data[k*DBITS +: DBITS] = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; valid = '0; last = '0; full = 1'b0;
    #3 check_zero("reset");
    @(negedge clk);
    nrst = 1'b1;
    gid_log.delete();
  endtask

  int pkt_left[NREQ];
  int silent[NREQ];

  // Stimulus: directed scenarios, then randomized packet traffic.
  initial begin : stim
    // Alternating pair with one-beat packets.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); valid = 4'b0101; last = 4'b1111; rand_data();
    end
    @(negedge clk); valid = '0;
    @(negedge clk); check_gids("rr_pair", 4, 32'h0202);

    // Four-beat packet is never interleaved with the waiting requester 3.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk); valid = 4'b1010; last = {1'b1, 1'b0, (k == 4), 1'b0}; rand_data();
    end
    @(negedge clk); valid = '0;
    @(negedge clk); check_gids("burst4", 5, 32'h11113);

    // FIFO full mid-burst holds the packet, last beat included.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); valid = 4'b0001; last = {3'b000, (k == 8)};
      full = (k >= 2 && k <= 6); rand_data();
    end
    @(negedge clk); valid = '0; full = 1'b0;
    @(negedge clk);
    check_gids("full_hold", 3, 32'h000);
    check("full_no_err", bus.o_err, 0);

    // Owner silent for exactly the timeout budget.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      valid = (k < 2) ? 4'b0011 : 4'b0010;
      last  = 4'b0010;
      rand_data();
      if (k == 18) #3 check("tmo_released", bus.o_busy, 0);
    end
    @(negedge clk); valid = '0;
    @(negedge clk);
    check_gids("timeout", 2, 32'h01);
    check("tmo_err", bus.o_err, 1);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", bus.o_err, 1);

    // Reset during beat 2 of a burst, pointer returns to 0.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      valid = 4'b1110; last = 4'b0010; rand_data();
      if (k == 4) begin
        nrst = 1'b0;
        #3 check_zero("mid_reset");
      end
      if (k == 5) nrst = 1'b1;
    end
    @(negedge clk); valid = '0;
    @(negedge clk); check_gids("reset_mid", 3, 32'h121);

    // All requesters busy with one-beat packets: full rotation and wrap.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); valid = 4'b1111; last = 4'b1111; rand_data();
    end
    @(negedge clk); valid = '0;
    @(negedge clk); check_gids("wrap", 5, 32'h01230);

    // Randomized traffic: packets of 1..4 beats, gaps, long silences, full, resets.
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      pkt_left[k] = 0;
      silent[k]   = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (m_acc >= 0 && pkt_left[m_acc] > 0) pkt_left[m_acc]--;
      for (int k = 0; k < NREQ; k++) begin
        if (pkt_left[k] == 0 && $urandom_range(0, 3) == 0) pkt_left[k] = $urandom_range(1, 4);
        if (silent[k] > 0) silent[k]--;
        else if ($urandom_range(0, 149) == 0) silent[k] = $urandom_range(10, 24);
        valid[k] = (pkt_left[k] > 0) && (silent[k] == 0) && ($urandom_range(0, 7) != 0);
        last[k]  = (pkt_left[k] == 1);
      end
      full = ($urandom_range(0, 4) == 0);
      nrst = ($urandom_range(0, 999) != 0);
      rand_data();
    end
    @(negedge clk); valid = '0; full = 1'b0; nrst = 1'b1;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/afifo_wr_arbiter.md
AFIFO_WR_ARBITER -- requirements
Module: afifo_wr_arbiter

Interface
REQ-001 SHALL have parameter nreq, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter dbits, default 32, meaning data width per beat.
REQ-003 SHALL have parameter tmo_cycles, default 16, meaning idle-stall cycles inside a burst before a forced release.
REQ-004 SHALL have port i_clk, input, 1, meaning clock (FIFO write domain).
REQ-005 SHALL have port i_nrst, input, 1, meaning reset, asynchronous, active-low.
REQ-006 SHALL have port i_req_valid, input, nreq, meaning per-requester beat valid.
REQ-007 SHALL have port i_req_data, input, nreq*dbits, meaning per-requester data; requester k occupies bits [k*dbits +: dbits].
REQ-008 SHALL have port i_req_last, input, nreq, meaning per-requester last beat of packet.
REQ-009 SHALL have port o_req_ready, output, nreq, meaning beat accepted this cycle.
REQ-010 SHALL have port i_full, input, 1, meaning async FIFO write-side full flag.
REQ-011 SHALL have port o_wena, output, 1, meaning FIFO write enable (drives the FIFO i_ena).
REQ-012 SHALL have port o_wdata, output, dbits+1, meaning {last, data} written to FIFO.
REQ-013 SHALL have port o_grant_id, output, $clog2(nreq), meaning current owner index.
REQ-014 SHALL have port o_busy, output, 1, meaning a burst is in progress.
REQ-015 SHALL have port o_err, output, 1, meaning sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE and BURST.
REQ-017 In IDLE with any i_req_valid set, SHALL select the first set requester at or after rr_ptr (wrapping modulo nreq), register it into o_grant_id, and go to BURST next cycle; no data SHALL be accepted in IDLE (1-cycle arbitration latency).
REQ-018 In IDLE with no valid requests, SHALL hold state and rr_ptr.
REQ-019 In BURST, o_wena SHALL equal i_req_valid[gid] AND NOT i_full, combinationally.
REQ-020 o_req_ready SHALL be one-hot at bit gid equal to o_wena; all other bits SHALL be 0.
REQ-021 o_wdata SHALL equal {i_req_last[gid], data of gid}, combinationally.
REQ-022 On a beat with i_req_last[gid]=1, SHALL return to IDLE and set rr_ptr to (gid+1) mod nreq.
REQ-023 Requests from non-owners during BURST SHALL be ignored; the packet is never interleaved.
REQ-024 SHALL use a stall counter of width $clog2(tmo_cycles+1), cleared on entry to BURST and on every beat, incremented when in BURST with i_req_valid[gid]=0; cycles with i_full=1 and valid=1 SHALL NOT count.
REQ-025 When the stall counter reaches tmo_cycles, SHALL go to IDLE, advance rr_ptr as in REQ-022, and set o_err=1 until reset.
REQ-026 When i_full=1, no beat SHALL be accepted and the state SHALL hold, even if i_req_last=1.
REQ-027 o_busy SHALL be 1 exactly in BURST.

Reset
REQ-028 On i_nrst=0, SHALL asynchronously set state=IDLE, rr_ptr=0, o_grant_id=0, stall counter=0, o_err=0; o_wena=0, o_req_ready=0, o_busy=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no further writes; the partial packet already in the FIFO is not repaired.

Structure
REQ-030 SHALL place the state enum (IDLE, BURST) and the idx-width helper in shared package afifo_arb_pkg.
REQ-031 SHALL implement round-robin selection in one combinational sub-module afifo_rr_pick (inputs: request vector, rr_ptr; outputs: found, index).
REQ-032 All FSM, counter, and pointer registers SHALL sit in a single asynchronous-reset always_ff block.

Verification
REQ-033 Reset, then valid=4'b0101, 1-beat packets -> grants 0, 2, 0, 2 in order; each write preceded by one IDLE cycle.
REQ-034 Requester 1 sends a 4-beat packet while requester 3 is valid -> 4 consecutive o_wena with gid=1, last set on beat 4, then gid=3.
REQ-035 i_full=1 for 5 cycles mid-burst with valid held -> o_wena=0 for those cycles, no timeout, and the burst completes after i_full drops.
REQ-036 Owner drops valid for 16 cycles (tmo_cycles=16) -> forced IDLE, o_err=1 and stays set, next grant goes to the next requester.
REQ-037 i_nrst pulsed low during beat 2 of a 3-beat burst -> all outputs 0 and rr_ptr=0; after release, the lowest-index valid requester wins.
REQ-038 All 4 requesters valid continuously with 1-beat packets -> grant sequence 0, 1, 2, 3, 0 (wrap-around).
